// File: rtl/sipo_rx_ctrl.sv
// rtl/sipo_rx_ctrl.sv - frame sequencer for an external sipo shift register (optional parity: SIPO_RX_CTRL_PARITY_EN)
module sipo_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_tick,
    input  logic                  rx_bit,
    input  logic                  abort,
    output logic                  sr_enable,
    output logic                  sr_set_ones,
    output logic                  sr_data,
    input  logic [DATA_WIDTH-1:0] sr_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

`ifdef SIPO_RX_CTRL_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd3
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  bad_parity;

`ifdef SIPO_RX_CTRL_PARITY_EN
    logic parity_q, parity_d;
    logic mismatch_q, mismatch_d;
    logic parity_err_q, parity_err_d;
    assign bad_parity = mismatch_q;
`else
    logic unused_odd_parity;
    assign unused_odd_parity = (ODD_PARITY != 0);
    assign bad_parity        = 1'b0;
`endif

    // State register and holding register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIPO_RX_CTRL_PARITY_EN
            parity_q     <= 1'b0;
            mismatch_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef SIPO_RX_CTRL_PARITY_EN
            parity_q     <= parity_d;
            mismatch_q   <= mismatch_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state, shift-register control, capture and handshake
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        sr_enable    = 1'b0;
        sr_set_ones  = 1'b0;
`ifdef SIPO_RX_CTRL_PARITY_EN
        parity_d     = parity_q;
        mismatch_d   = mismatch_q;
        parity_err_d = 1'b0;
`endif

        // Consumer takes the word; a same-cycle capture below overrides this
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q != S_IDLE && abort) begin
            // Abort wins over a coincident tick; re-preload the register
            sr_enable   = 1'b1;
            sr_set_ones = 1'b1;
            state_d     = S_IDLE;
        end else if (bit_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_bit) begin
                        sr_enable   = 1'b1;
                        sr_set_ones = 1'b1;
                        cnt_d       = '0;
`ifdef SIPO_RX_CTRL_PARITY_EN
                        parity_d    = 1'b0;
                        mismatch_d  = 1'b0;
`endif
                        state_d     = S_DATA;
                    end
                end
                S_DATA: begin
                    sr_enable = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
`ifdef SIPO_RX_CTRL_PARITY_EN
                    parity_d  = parity_q ^ rx_bit;
                    if (cnt_q == LAST_BIT) begin
                        state_d = S_PARITY;
                    end
`else
                    if (cnt_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end
`endif
                end
`ifdef SIPO_RX_CTRL_PARITY_EN
                S_PARITY: begin
                    mismatch_d = ((parity_q ^ rx_bit) != (ODD_PARITY != 0));
                    state_d    = S_STOP;
                end
`endif
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!rx_bit) begin
                        frame_err_d = 1'b1;
                    end else if (bad_parity) begin
`ifdef SIPO_RX_CTRL_PARITY_EN
                        parity_err_d = 1'b1;
`endif
                    end else if (!out_valid_q || out_ready) begin
                        out_data_d  = sr_q;
                        out_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign sr_data   = rx_bit;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);
`ifdef SIPO_RX_CTRL_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// tb/tb_sipo_rx_ctrl.sv - self-checking bench for sipo_rx_ctrl with a behavioural sipo
module tb_sipo_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_tick = 1'b0;
    logic       rx_bit = 1'b1;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;
    logic       sr_enable, sr_set_ones, sr_data;
    logic [7:0] sr_q, out_data;
    logic       out_valid, frame_err, parity_err, overrun, busy;

    always #5 clk = ~clk;

    sipo_rx_ctrl #(.DATA_WIDTH(8), .ODD_PARITY(0)) dut (
        .clk(clk), .reset(rst), .bit_tick(bit_tick), .rx_bit(rx_bit), .abort(abort),
        .sr_enable(sr_enable), .sr_set_ones(sr_set_ones), .sr_data(sr_data), .sr_q(sr_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    // Behavioural shift register: preload ones, shift in at the MSB (LSB-first line)
    logic [7:0] sr_model = 8'h00;
    always @(posedge clk) begin
        if (sr_enable) sr_model <= sr_set_ones ? 8'hFF : {sr_data, sr_model[7:1]};
    end
    assign sr_q = sr_model;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0, ones_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on handshakes, pulse counters
    always @(negedge clk) begin
        if (!rst) begin
            if (sr_enable && sr_set_ones) ones_cnt++;
            if (frame_err) ferr_cnt++;
            if (parity_err) perr_cnt++;
            if (overrun) ovr_cnt++;
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h required=none", out_data);
                end else begin
                    check("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic b);
        bit_tick = 1'b1;
        rx_bit   = b;
        @(posedge clk);
        #1;
        bit_tick = 1'b0;
        rx_bit   = 1'b1;
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        tick(1'b0);
        idle();
        for (int i = 0; i < 8; i++) begin
            tick(d[i]);
            idle();
        end
`ifdef SIPO_RX_CTRL_PARITY_EN
        tick(par);
        idle();
`else
        if (par === 1'bz) idle();
`endif
        tick(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base, base2;
        vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h6B, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hFE, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_errs", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        rst = 1'b0;
        idle();

        // Good frame 0xA5
        base = ones_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, good_par(8'hA5));
        check("a5_valid", {31'd0, out_valid}, 32'd1);
        check("a5_data", {24'd0, out_data}, 32'hA5);
        check("a5_idle", {31'd0, busy}, 32'd0);
        idle();
        check("a5_valid_drop", {31'd0, out_valid}, 32'd0);
        check("a5_set_ones_cnt", base == 0 ? ones_cnt : ones_cnt - base, 32'd1);

        // Framing error 0x3C
        base = ferr_cnt;
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        check("ferr_pulse", {31'd0, frame_err}, 32'd1);
        check("ferr_valid", {31'd0, out_valid}, 32'd0);
        check("ferr_idle", {31'd0, busy}, 32'd0);
        idle();
        check("ferr_width", {31'd0, frame_err}, 32'd0);
        check("ferr_cnt", ferr_cnt - base, 32'd1);

        // Table of frames with the consumer always ready
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop, good_par(vecs[i].data));
            check("tbl_valid", {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            check("tbl_ferr", {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
            if (vecs[i].exp_valid) check("tbl_data", {24'd0, out_data}, {24'd0, vecs[i].data});
            idle();
            idle();
        end

        // Overrun with consumer stalled
        out_ready = 1'b0;
        base = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, good_par(8'h11));
        check("ovr_first_valid", {31'd0, out_valid}, 32'd1);
        idle();
        send_frame(8'h22, 1'b1, good_par(8'h22));
        check("ovr_pulse", {31'd0, overrun}, 32'd1);
        check("ovr_kept", {24'd0, out_data}, 32'h11);
        idle();
        check("ovr_width", {31'd0, overrun}, 32'd0);
        repeat (3) idle();
        check("ovr_hold_valid", {31'd0, out_valid}, 32'd1);
        check("ovr_hold_data", {24'd0, out_data}, 32'h11);
        base2 = xfer_cnt;
        out_ready = 1'b1;
        repeat (4) idle();
        check("ovr_one_xfer", xfer_cnt - base2, 32'd1);
        check("ovr_cnt", ovr_cnt - base, 32'd1);
        check("ovr_drained", {31'd0, out_valid}, 32'd0);

        // Abort coincident with the fifth data tick
        base = ferr_cnt + perr_cnt + ovr_cnt;
        tick(1'b0);
        idle();
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(i[0]);
            idle();
        end
        bit_tick = 1'b1;
        abort    = 1'b1;
        rx_bit   = 1'b1;
        @(negedge clk);
        check("abort_ctrl", {30'd0, sr_enable, sr_set_ones}, 32'd3);
        @(posedge clk);
        #1;
        bit_tick = 1'b0;
        abort    = 1'b0;
        check("abort_idle", {31'd0, busy}, 32'd0);
        idle();
        idle();
        check("abort_no_err", ferr_cnt + perr_cnt + ovr_cnt - base, 32'd0);
        check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, good_par(8'h5A));
        check("post_abort_valid", {31'd0, out_valid}, 32'd1);
        check("post_abort_data", {24'd0, out_data}, 32'h5A);
        idle();

`ifdef SIPO_RX_CTRL_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_ok_valid", {31'd0, out_valid}, 32'd1);
        check("par_ok_data", {24'd0, out_data}, 32'h07);
        idle();
        base = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_err_pulse", {31'd0, parity_err}, 32'd1);
        check("par_err_valid", {31'd0, out_valid}, 32'd0);
        idle();
        check("par_err_cnt", perr_cnt - base, 32'd1);
`else
        check("par_tied_off", perr_cnt, 32'd0);
`endif

        // Asynchronous reset mid-frame with a word pending
        out_ready = 1'b0;
        send_frame(8'h33, 1'b1, good_par(8'h33));
        check("rstmid_pending", {31'd0, out_valid}, 32'd1);
        idle();
        tick(1'b0);
        idle();
        tick(1'b1);
        idle();
        tick(1'b0);
        check("rstmid_busy_pre", {31'd0, busy}, 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_data", {24'd0, out_data}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) idle();
        check("rstmid_after", {30'd0, out_valid, busy}, 32'd0);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
